// File: rtl/conv_pkg.sv
// Shared definitions for the convolver result buffer.
package conv_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 16;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] result_t;

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// Pointer, occupancy and status/error control for the circular result buffer.
// Decides which push/pop requests are accepted; storage lives in the parent.
module fifo_ptr_ctrl #(
    parameter  int unsigned DEPTH        = 1352,
    parameter  int unsigned AFULL_LEVEL  = DEPTH - 4,
    parameter  int unsigned AEMPTY_LEVEL = 4,
    localparam int unsigned ADDR_W       = $clog2(DEPTH),
    localparam int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              wenable,
    input  logic              renable,
    output logic              wr_ok,
    output logic              rd_ok,
    output logic [ADDR_W-1:0] waddr,
    output logic [ADDR_W-1:0] raddr,
    output logic [CNT_W-1:0]  count,
    output logic              empty,
    output logic              full,
    output logic              almost_empty,
    output logic              almost_full,
    output logic              overflow,
    output logic              underflow
);

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic              underflow_q, underflow_d;

    // Flags decode straight from the registered count so they carry no extra latency.
    assign empty        = (count_q == '0);
    assign full         = (count_q == CNT_W'(DEPTH));
    assign almost_empty = (count_q <= CNT_W'(AEMPTY_LEVEL));
    assign almost_full  = (count_q >= CNT_W'(AFULL_LEVEL));

    assign waddr     = waddr_q;
    assign raddr     = raddr_q;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

    always_comb begin
        // No bypass: a pop on empty is refused even alongside a push.
        rd_ok = !clear && renable && !empty;
        wr_ok = !clear && wenable && (!full || rd_ok);

        waddr_d     = waddr_q;
        raddr_d     = raddr_q;
        count_d     = count_q;
        overflow_d  = overflow_q | (!clear && wenable && !wr_ok);
        underflow_d = underflow_q | (!clear && renable && !rd_ok);

        if (wr_ok) begin
            waddr_d = (waddr_q == LastAddr) ? '0 : waddr_q + ADDR_W'(1);
        end
        if (rd_ok) begin
            raddr_d = (raddr_q == LastAddr) ? '0 : raddr_q + ADDR_W'(1);
        end

        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (clear) begin
            waddr_d     = '0;
            raddr_d     = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            waddr_q     <= '0;
            raddr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            waddr_q     <= waddr_d;
            raddr_q     <= raddr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: rtl/conv_result_fifo.sv
// Parametrised circular result buffer between the conv engine (push) and the
// AHB slave (pop). Holds the storage array and the registered read port.
module conv_result_fifo
    import conv_pkg::*;
#(
    parameter  int unsigned DATA_WIDTH   = DEFAULT_DATA_WIDTH,
    parameter  int unsigned DEPTH        = 1352,
    parameter  int unsigned AFULL_LEVEL  = DEPTH - 4,
    parameter  int unsigned AEMPTY_LEVEL = 4,
    localparam int unsigned ADDR_W       = $clog2(DEPTH),
    localparam int unsigned CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  clear,
    input  logic                  wenable,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  renable,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  rvalid,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full,
    output logic [CNT_W-1:0]      count,
    output logic                  overflow,
    output logic                  underflow
);

    logic              wr_ok, rd_ok;
    logic [ADDR_W-1:0] waddr, raddr;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    fifo_ptr_ctrl #(
        .DEPTH        (DEPTH),
        .AFULL_LEVEL  (AFULL_LEVEL),
        .AEMPTY_LEVEL (AEMPTY_LEVEL)
    ) u_ptr_ctrl (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .wenable      (wenable),
        .renable      (renable),
        .wr_ok        (wr_ok),
        .rd_ok        (rd_ok),
        .waddr        (waddr),
        .raddr        (raddr),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    // Unreset so the array maps onto RAM.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        if (clear) begin
            rdata_d = '0;
        end else if (rd_ok) begin
            rdata_d  = mem[raddr];
            rvalid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign rdata  = rdata_q;
    assign rvalid = rvalid_q;

endmodule

// File: tb/tb_conv_result_fifo.sv
// Directed, table-driven bench for conv_result_fifo at DEPTH=4.
module tb_conv_result_fifo;

    localparam int unsigned DW = 16;

    logic          clk;
    logic          n_rst;
    logic          clear;
    logic          wenable;
    logic [DW-1:0] wdata;
    logic          renable;
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          empty;
    logic          full;
    logic          almost_empty;
    logic          almost_full;
    logic [2:0]    count;
    logic          overflow;
    logic          underflow;

    conv_result_fifo #(
        .DATA_WIDTH   (DW),
        .DEPTH        (4),
        .AFULL_LEVEL  (3),
        .AEMPTY_LEVEL (1)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .clear        (clear),
        .wenable      (wenable),
        .wdata        (wdata),
        .renable      (renable),
        .rdata        (rdata),
        .rvalid       (rvalid),
        .empty        (empty),
        .full         (full),
        .almost_empty (almost_empty),
        .almost_full  (almost_full),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed bundle: {rdata, rvalid, count, empty, full, aempty, afull, ovf, unf}
    typedef logic [25:0] obs_t;

    typedef struct {
        string         name;
        logic          clr;
        logic          wen;
        logic [DW-1:0] wd;
        logic          ren;
        logic [DW-1:0] rd;
        logic          rv;
        logic [2:0]    cnt;
        logic          e, f, ae, af, ov, un;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    function automatic obs_t observe();
        return {rdata, rvalid, count, empty, full, almost_empty, almost_full, overflow, underflow};
    endfunction

    task automatic check(input string name, input obs_t exp);
        obs_t act;
        act = observe();
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got rdata=%h rv=%b cnt=%0d e/f/ae/af/ov/un=%b, want rdata=%h rv=%b cnt=%0d e/f/ae/af/ov/un=%b",
                     name, act[25:10], act[9], act[8:6], act[5:0], exp[25:10], exp[9], exp[8:6],
                     exp[5:0]);
        end
    endtask

    task automatic add(input string name, input logic clr, input logic wen, input logic [DW-1:0] wd,
                       input logic ren, input logic [DW-1:0] rd, input logic rv,
                       input logic [2:0] cnt, input logic [5:0] flags);
        vec_t v;
        v.name = name; v.clr = clr; v.wen = wen; v.wd = wd; v.ren = ren;
        v.rd = rd; v.rv = rv; v.cnt = cnt;
        {v.e, v.f, v.ae, v.af, v.ov, v.un} = flags;
        vecs.push_back(v);
    endtask

    // One clock with the given inputs, then sample 1 time unit after the edge.
    task automatic step(input logic clr, input logic wen, input logic [DW-1:0] wd, input logic ren);
        clear = clr; wenable = wen; wdata = wd; renable = ren;
        @(posedge clk);
        #1;
        clear = 1'b0; wenable = 1'b0; renable = 1'b0;
    endtask

    initial begin
        //                name        clr wen wdata     ren rdata     rv cnt  e f ae af ov un
        add("fill0",      0, 1, 16'h0011, 0, 16'h0000, 0, 1, 6'b001000);
        add("fill1",      0, 1, 16'h0022, 0, 16'h0000, 0, 2, 6'b000000);
        add("fill2",      0, 1, 16'h0033, 0, 16'h0000, 0, 3, 6'b000100);
        add("fill3",      0, 1, 16'h0044, 0, 16'h0000, 0, 4, 6'b010100);
        add("drain0",     0, 0, 16'h0000, 1, 16'h0011, 1, 3, 6'b000100);
        add("drain1",     0, 0, 16'h0000, 1, 16'h0022, 1, 2, 6'b000000);
        add("drain2",     0, 0, 16'h0000, 1, 16'h0033, 1, 1, 6'b001000);
        add("drain3",     0, 0, 16'h0000, 1, 16'h0044, 1, 0, 6'b101000);
        add("hold",       0, 0, 16'h0000, 0, 16'h0044, 0, 0, 6'b101000);
        add("clear0",     1, 0, 16'h0000, 0, 16'h0000, 0, 0, 6'b101000);
        add("pre_push0",  0, 1, 16'h0001, 0, 16'h0000, 0, 1, 6'b001000);
        add("pre_push1",  0, 1, 16'h0002, 0, 16'h0000, 0, 2, 6'b000000);
        add("pre_push2",  0, 1, 16'h0003, 0, 16'h0000, 0, 3, 6'b000100);
        add("pre_pop0",   0, 0, 16'h0000, 1, 16'h0001, 1, 2, 6'b000000);
        add("pre_pop1",   0, 0, 16'h0000, 1, 16'h0002, 1, 1, 6'b001000);
        add("pre_pop2",   0, 0, 16'h0000, 1, 16'h0003, 1, 0, 6'b101000);
        add("wrap_push0", 0, 1, 16'h00A0, 0, 16'h0003, 0, 1, 6'b001000);
        add("wrap_push1", 0, 1, 16'h00A1, 0, 16'h0003, 0, 2, 6'b000000);
        add("wrap_push2", 0, 1, 16'h00A2, 0, 16'h0003, 0, 3, 6'b000100);
        add("wrap_push3", 0, 1, 16'h00A3, 0, 16'h0003, 0, 4, 6'b010100);
        add("full_pushpop", 0, 1, 16'h00B0, 1, 16'h00A0, 1, 4, 6'b010100);
        add("push_full",  0, 1, 16'h00C0, 0, 16'h00A0, 0, 4, 6'b010110);
        add("pop_a1",     0, 0, 16'h0000, 1, 16'h00A1, 1, 3, 6'b000110);
        add("pop_a2",     0, 0, 16'h0000, 1, 16'h00A2, 1, 2, 6'b000010);
        add("pop_a3",     0, 0, 16'h0000, 1, 16'h00A3, 1, 1, 6'b001010);
        add("pop_b0",     0, 0, 16'h0000, 1, 16'h00B0, 1, 0, 6'b101010);
        add("pop_empty",  0, 0, 16'h0000, 1, 16'h00B0, 0, 0, 6'b101011);
        add("clear1",     1, 0, 16'h0000, 0, 16'h0000, 0, 0, 6'b101000);
        add("empty_pushpop", 0, 1, 16'h00D0, 1, 16'h0000, 0, 1, 6'b001001);
        add("pop_d0",     0, 0, 16'h0000, 1, 16'h00D0, 1, 0, 6'b101001);
        add("clear_req",  1, 1, 16'h00EE, 1, 16'h0000, 0, 0, 6'b101000);
        add("after_clr",  0, 0, 16'h0000, 1, 16'h0000, 0, 0, 6'b101001);
        add("clear2",     1, 0, 16'h0000, 0, 16'h0000, 0, 0, 6'b101000);

        n_rst = 1'b0; clear = 1'b0; wenable = 1'b0; wdata = '0; renable = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_state", {16'h0000, 1'b0, 3'd0, 6'b101000});
        @(negedge clk);
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        check("post_release", {16'h0000, 1'b0, 3'd0, 6'b101000});

        foreach (vecs[i]) begin
            step(vecs[i].clr, vecs[i].wen, vecs[i].wd, vecs[i].ren);
            check(vecs[i].name, {vecs[i].rd, vecs[i].rv, vecs[i].cnt, vecs[i].e, vecs[i].f,
                                 vecs[i].ae, vecs[i].af, vecs[i].ov, vecs[i].un});
        end

        // Asynchronous reset with count=2 and rvalid high, applied between clock edges.
        step(1'b0, 1'b1, 16'h00E0, 1'b0);
        step(1'b0, 1'b1, 16'h00E1, 1'b0);
        step(1'b0, 1'b1, 16'h00E2, 1'b0);
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        check("pre_async", {16'h00E0, 1'b1, 3'd2, 6'b000000});
        #1;
        n_rst = 1'b0;
        #1;
        check("async_reset", {16'h0000, 1'b0, 3'd0, 6'b101000});
        @(negedge clk);
        n_rst = 1'b1;
        step(1'b0, 1'b1, 16'h00F0, 1'b0);
        check("rst_push", {16'h0000, 1'b0, 3'd1, 6'b001000});
        step(1'b0, 1'b0, 16'h0000, 1'b1);
        check("rst_pop", {16'h00F0, 1'b1, 3'd0, 6'b101000});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
